// File: rtl/imem_boot_controller.sv
// Boot sequencer for the instruction memory: NOP-fills the array, loads a host image,
// then lets the core fetch. Owns the memory write port and the fetch read-address path.
module imem_boot_controller #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned ADDR_W   = 6,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       core_pc,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr_out,
    output logic              core_run,
    output logic              fetch_fault,
    output logic              load_error,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              load_error_q, load_error_d;
    logic [31:0]       checksum_q, checksum_d;

    logic start_ok;
    logic xfer;
    logic last_xfer;
    logic pc_fault;

    // A zero-length or oversize image is refused before anything is touched.
    assign start_ok  = (load_count != '0) && (load_count <= DEPTH_C);
    assign xfer      = (state_q == S_LOAD) && in_valid;
    assign last_xfer = xfer && ({1'b0, ptr_q} == (count_q - CNT_ONE));
    assign pc_fault  = (core_pc[1:0] != 2'b00) || (core_pc[31:ADDR_W+2] != '0);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        load_error_d = load_error_q;
        checksum_d   = checksum_q;
        unique case (state_q)
            S_CLEAR: begin
                ptr_d = ptr_q + PTR_ONE;
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end
            end
            S_IDLE, S_RUN: begin
                if (load_start) begin
                    if (start_ok) begin
                        count_d      = load_count;
                        load_error_d = 1'b0;
                        checksum_d   = '0;
                        ptr_d        = '0;
                        state_d      = S_LOAD;
                    end else begin
                        load_error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    checksum_d = checksum_q + in_data;
                    ptr_d      = ptr_q + PTR_ONE;
                    if (last_xfer) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            count_q      <= '0;
            load_error_q <= 1'b0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            load_error_q <= load_error_d;
            checksum_q   <= checksum_d;
        end
    end

    // Write port is combinational from state so an accepted word lands on the same edge.
    assign in_ready  = (state_q == S_LOAD);
    assign mem_we    = (state_q == S_CLEAR) || xfer;
    assign mem_waddr = ptr_q;
    assign mem_wdata = (state_q == S_LOAD) ? in_data : NOP_WORD;

    assign mem_raddr   = core_pc[ADDR_W+1:2];
    assign core_run    = (state_q == S_RUN);
    assign fetch_fault = core_run && pc_fault;
    assign instr_out   = (core_run && !pc_fault) ? mem_rdata : NOP_WORD;

    assign load_error = load_error_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_boot_controller.sv
// Bench for imem_boot_controller: behavioural memory, scoreboard of expected image/status,
// per-cycle comparison on the falling edge plus hand-computed literal checks.
module tb_imem_boot_controller;

    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW:0]   load_count;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   core_pc;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic [31:0]   instr_out;
    logic          core_run;
    logic          fetch_fault;
    logic          load_error;
    logic [31:0]   checksum;

    imem_boot_controller #(
        .DEPTH(DEPTH),
        .ADDR_W(AW),
        .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_start(load_start),
        .load_count(load_count),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .core_pc(core_pc),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .instr_out(instr_out),
        .core_run(core_run),
        .fetch_fault(fetch_fault),
        .load_error(load_error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // The instruction memory array the controller drives.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    // Scoreboard state.
    logic [31:0]   exp_img [DEPTH];
    logic          exp_run, exp_ready, exp_err, exp_we;
    logic [31:0]   exp_sum, exp_wdata;
    logic [AW-1:0] exp_waddr;
    logic          chk_en;
    logic [31:0]   wbuf [DEPTH];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic pc_bad(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc >= DEPTH * 4);
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] pc);
        if (!exp_run || pc_bad(pc)) return NOP;
        return exp_img[pc / 4];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("core_run",    32'(core_run),    32'(exp_run));
            check("in_ready",    32'(in_ready),    32'(exp_ready));
            check("load_error",  32'(load_error),  32'(exp_err));
            check("checksum",    checksum,         exp_sum);
            check("instr_out",   instr_out,        model_instr(core_pc));
            check("fetch_fault", 32'(fetch_fault), 32'(exp_run && pc_bad(core_pc)));
            check("mem_raddr",   32'(mem_raddr),   (core_pc >> 2) % DEPTH);
            check("mem_we",      32'(mem_we),      32'(exp_we));
            if (exp_we) begin
                check("mem_waddr", 32'(mem_waddr), 32'(exp_waddr));
                check("mem_wdata", mem_wdata,      exp_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk_en     = 1'b0;
        in_valid   = 1'b0;
        load_start = 1'b0;
        core_pc    = 32'h0;
        reset      = 1'b1;
        #2;
        check("rst core_run",   32'(core_run),   32'h0);
        check("rst in_ready",   32'(in_ready),   32'h0);
        check("rst load_error", 32'(load_error), 32'h0);
        check("rst checksum",   checksum,        32'h0);
        check("rst instr_out",  instr_out,       32'h0000_0013);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_run   = 1'b0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_sum   = 32'h0;
        for (int i = 0; i < DEPTH; i++) exp_img[i] = NOP;
        exp_we    = 1'b1;
        exp_wdata = NOP;
        chk_en    = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_waddr = AW'(i);
            tick();
        end
        exp_we = 1'b0;
    endtask

    // Feeds 'fed' of the first words of an n-word load; gap bit k inserts an idle cycle before word k.
    task automatic do_load(input int n, input int fed, input int gaps);
        load_start = 1'b1;
        load_count = (AW+1)'(n);
        tick();
        load_start = 1'b0;
        exp_ready  = 1'b1;
        exp_run    = 1'b0;
        exp_err    = 1'b0;
        exp_sum    = 32'h0;
        for (int k = 0; k < fed; k++) begin
            if (k < 32 && gaps[k]) begin
                in_valid = 1'b0;
                exp_we   = 1'b0;
                tick();
            end
            in_valid  = 1'b1;
            in_data   = wbuf[k];
            exp_we    = 1'b1;
            exp_waddr = AW'(k);
            exp_wdata = wbuf[k];
            tick();
            exp_img[k] = wbuf[k];
            exp_sum    = exp_sum + wbuf[k];
        end
        in_valid = 1'b0;
        exp_we   = 1'b0;
        if (fed == n) begin
            exp_ready = 1'b0;
            exp_run   = 1'b1;
        end
    endtask

    task automatic reject(input int cnt);
        load_start = 1'b1;
        load_count = (AW+1)'(cnt);
        tick();
        load_start = 1'b0;
        exp_err    = 1'b1;
    endtask

    task automatic sweep();
        for (int k = 0; k < DEPTH; k++) begin
            core_pc = 32'(k * 4);
            tick();
        end
        core_pc = 32'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        load_start = 1'b0;
        load_count = '0;
        in_valid   = 1'b0;
        in_data    = 32'h0;
        core_pc    = 32'h0;
        chk_en     = 1'b0;
        exp_run    = 1'b0;
        exp_ready  = 1'b0;
        exp_err    = 1'b0;
        exp_we     = 1'b0;
        exp_sum    = 32'h0;
        exp_wdata  = 32'h0;
        exp_waddr  = '0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_reset();
        tick();

        reject(0);
        tick();
        check("err after count0", 32'(load_error), 32'h1);
        reject(65);
        tick();

        wbuf[0] = 32'h00C8_0693;
        wbuf[1] = 32'h4034_0293;
        wbuf[2] = 32'h0031_70B3;
        do_load(3, 3, 32'b0110);
        check("3w checksum", checksum, 32'h412D_79D9);
        check("3w core_run", 32'(core_run), 32'h1);
        check("3w load_error", 32'(load_error), 32'h0);
        core_pc = 32'h4;
        #1;
        check("pc4 instr", instr_out, 32'h4034_0293);
        tick();
        core_pc = 32'h102;
        #1;
        check("pc102 fault", 32'(fetch_fault), 32'h1);
        check("pc102 instr", instr_out, 32'h0000_0013);
        tick();
        core_pc = 32'h100;
        #1;
        check("pc100 fault", 32'(fetch_fault), 32'h1);
        tick();
        core_pc = 32'hFC;
        #1;
        check("pcFC instr nop", instr_out, 32'h0000_0013);
        tick();

        reject(0);
        tick();
        check("run reject run", 32'(core_run), 32'h1);

        wbuf[0] = 32'h0050_0113;
        do_load(1, 1, 0);
        sweep();

        for (int k = 0; k < DEPTH; k++) wbuf[k] = {8'hA5, 8'(k), 16'h1234};
        do_load(64, 64, 32'h5);
        core_pc = 32'hFC;
        #1;
        check("full pcFC instr", instr_out, 32'hA53F_1234);
        repeat (3) tick();
        sweep();

        for (int k = 0; k < 5; k++) wbuf[k] = 32'h0100_0093 + 32'(k);
        do_load(5, 2, 0);
        do_reset();
        tick();
        wbuf[0] = 32'h0070_0193;
        do_load(1, 1, 0);
        sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_controller.md
# imem_boot_controller

Sequences the single-cycle core's instruction memory: after reset it fills every word with NOP, then loads a program streamed from a host over a valid/ready port, then releases the core to fetch. It owns the only write port and the read-address mux of the instruction memory, and it holds the core in NOP until a complete image is resident. It sits between the host/debug link, the instruction memory array and the core's PC/fetch path.

## Interface
- DEPTH, 64, instruction memory size in 32-bit words (power of two)
- ADDR_W, 6, log2(DEPTH), word-address width
- NOP_WORD, 32'h0000_0013, fill and idle instruction (addi x0,x0,0)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all registers immediately
- load_start  in  1  one-cycle request to begin a program load
- load_count  in  ADDR_W+1  number of words to load, sampled with load_start
- in_valid  in  1  host word valid
- in_data  in  32  host instruction word
- in_ready  out  1  controller accepts in_data this cycle
- mem_we  out  1  instruction memory write enable (synchronous write)
- mem_waddr  out  ADDR_W  write word address
- mem_wdata  out  32  write data
- core_pc  in  32  core byte PC
- mem_raddr  out  ADDR_W  read word address = core_pc[ADDR_W+1:2]
- mem_rdata  in  32  combinational read data from memory
- instr_out  out  32  instruction delivered to core decode
- core_run  out  1  core may advance PC; 0 holds core
- fetch_fault  out  1  misaligned or out-of-range PC during RUN
- load_error  out  1  sticky: last load_start rejected
- checksum  out  32  sum mod 2^32 of words of last load

## Operation
- States: CLEAR, IDLE, LOAD, RUN. Reset enters CLEAR with ptr=0.
- CLEAR: mem_we=1, mem_waddr=ptr, mem_wdata=NOP_WORD; ptr increments each cycle; after writing DEPTH-1, go IDLE, ptr=0. load_start ignored.
- IDLE: on load_start, if load_count==0 or load_count>DEPTH, set load_error, stay IDLE; else latch count, clear load_error, checksum=0, ptr=0, go LOAD.
- LOAD: in_ready=1. Transfer when in_valid&&in_ready: mem_we=1, mem_waddr=ptr, mem_wdata=in_data, checksum+=in_data, ptr++. The transfer with ptr==count-1 moves to RUN. No transfer leaves state unchanged. load_start ignored.
- RUN: core_run=1. instr_out=mem_rdata unless fetch_fault. fetch_fault=1 when core_pc[1:0]!=0 or core_pc[31:ADDR_W+2]!=0; then instr_out=NOP_WORD. load_start in RUN is validated as in IDLE: accepted goes LOAD (core_run drops next cycle); rejected sets load_error, stays RUN.
- Outside RUN: instr_out=NOP_WORD, core_run=0, fetch_fault=0.
- Locations beyond count keep prior contents (NOP after CLEAR, or earlier load).
- mem_raddr always driven from core_pc, independent of state.

## Timing
- Reset values: state CLEAR, ptr 0, core_run 0, in_ready 0, load_error 0, checksum 0, mem_we 1 from first clock after release (combinational from state), instr_out NOP_WORD.
- CLEAR lasts exactly DEPTH cycles; IDLE first visible in cycle DEPTH after reset release.
- in_ready, mem_we, mem_waddr, mem_wdata, core_run are functions of registered state (mem_we/wdata in LOAD also of in_valid/in_data); no extra latency: the word accepted on edge N is written on edge N.
- core_run rises the cycle after the final transfer; N-word load takes N transfer cycles minimum.
- instr_out and fetch_fault combinational from core_pc/mem_rdata (single-cycle fetch).
- Reset asserted mid-LOAD or mid-RUN: immediate return to CLEAR; partially loaded image is overwritten by NOP.
- load_count is width ADDR_W+1 so load_count==DEPTH is legal.

## Test plan
- Reset release, DEPTH=64 -> 64 consecutive writes of 0x00000013 to addrs 0..63, IDLE at cycle 64, instr_out=0x00000013, core_run=0.
- load_start with load_count=3, words 0x00C80693,0x40340293,0x003170B3 with in_valid gaps -> writes at 0,1,2 only on valid cycles, checksum=sum mod 2^32, core_run=1 one cycle after third word; core_pc=4 -> instr_out=0x40340293.
- load_count=0, then load_count=65 -> load_error=1, state unchanged, no memory writes; following valid load_count=1 clears load_error.
- In RUN, core_pc=0x102 -> fetch_fault=1, instr_out=NOP; core_pc=0x100 -> fetch_fault=1; core_pc=0xFC -> word 63 returned.
- load_count=64 full image -> ptr wraps to last address 63, core_run after 64th transfer, no write to address 0 after it.
- Reset pulsed after 2 of 5 load words -> core_run=0 immediately, CLEAR rewrites all 64 words, load_error=0, checksum=0.
